// File: rtl/word_stack.sv
// Parametrised LIFO operand stack for the stack calculator datapath.
// s[0] is the top of stack; entries at or below depth are kept at zero.
module word_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int DW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] din,
    input  logic             err_clr,
    output logic [WIDTH-1:0] top,
    output logic [WIDTH-1:0] second,
    output logic [DW-1:0]    depth,
    output logic             empty,
    output logic             full,
    output logic             err
);

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_PUSH  = 3'd1,
        OP_POP   = 3'd2,
        OP_SWAP  = 3'd3,
        OP_DUP   = 3'd4,
        OP_OVER  = 3'd5,
        OP_ROT   = 3'd6,
        OP_CLEAR = 3'd7
    } op_t;

    logic [WIDTH-1:0] s      [DEPTH];
    logic [WIDTH-1:0] s_next [DEPTH];
    logic [DW-1:0]    depth_next;
    logic             fail;
    logic             push_en;
    logic [WIDTH-1:0] push_data;

    assign top    = s[0];
    assign second = s[1];
    assign empty  = (depth == '0);
    assign full   = (depth == DW'(DEPTH));

    always_comb begin
        s_next     = s;
        depth_next = depth;
        fail       = 1'b0;
        push_en    = 1'b0;
        push_data  = din;
        if (op_valid) begin
            case (op_t'(op))
                OP_PUSH: push_en = 1'b1;
                OP_POP: begin
                    if (empty) begin
                        fail = 1'b1;
                    end else begin
                        for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                            s_next[i] = s[i+1];
                        end
                        s_next[DEPTH-1] = '0;
                        depth_next      = depth - DW'(1);
                    end
                end
                OP_SWAP: begin
                    if (depth < DW'(2)) begin
                        fail = 1'b1;
                    end else begin
                        s_next[0] = s[1];
                        s_next[1] = s[0];
                    end
                end
                OP_DUP: begin
                    if (empty) begin
                        fail = 1'b1;
                    end else begin
                        push_en   = 1'b1;
                        push_data = s[0];
                    end
                end
                OP_OVER: begin
                    if (depth < DW'(2)) begin
                        fail = 1'b1;
                    end else begin
                        push_en   = 1'b1;
                        push_data = s[1];
                    end
                end
                OP_ROT: begin
                    if (depth < DW'(3)) begin
                        fail = 1'b1;
                    end else begin
                        s_next[0] = s[2];
                        s_next[1] = s[0];
                        s_next[2] = s[1];
                    end
                end
                OP_CLEAR: begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        s_next[i] = '0;
                    end
                    depth_next = '0;
                end
                default: ;
            endcase
        end
        // PUSH, DUP and OVER share one shift-down path; a full stack drops its bottom entry
        if (push_en) begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                s_next[i] = s[i-1];
            end
            s_next[0] = push_data;
            if (full) begin
                fail = 1'b1;
            end else begin
                depth_next = depth + DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                s[i] <= '0;
            end
            depth <= '0;
            err   <= 1'b0;
        end else begin
            s     <= s_next;
            depth <= depth_next;
            err   <= fail | (err & ~err_clr);
        end
    end

endmodule

// File: tb/tb_word_stack.sv
// Self-checking bench for word_stack: queue-based reference model checked every cycle,
// plus directed literal expectations taken from hand-worked sequences.
module tb_word_stack;

    logic       clk = 1'b0;
    logic       rst;
    logic       op_valid;
    logic [2:0] op;
    logic [7:0] din;
    logic       err_clr;
    logic [7:0] top;
    logic [7:0] second;
    logic [2:0] depth;
    logic       empty;
    logic       full;
    logic       err;

    int checks = 0;
    int errors = 0;

    word_stack #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .din(din),
        .err_clr(err_clr), .top(top), .second(second), .depth(depth),
        .empty(empty), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, SWAP = 3'd3,
                           DUP = 3'd4, OVER = 3'd5, ROT = 3'd6, CLR = 3'd7;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: q[0] is the top of stack, size is the depth.
    logic [7:0] q[$];
    bit         merr;
    bit         mvalid = 1'b0;

    always @(posedge clk) begin
        bit         f;
        logic [7:0] d, a, b, c;
        f = 1'b0;
        if (rst) begin
            q.delete();
            merr   = 1'b0;
            mvalid = 1'b1;
        end else if (mvalid) begin
            if (op_valid) begin
                case (op)
                    PUSH, DUP, OVER: begin
                        if ((op == DUP && q.size() < 1) || (op == OVER && q.size() < 2)) begin
                            f = 1'b1;
                        end else begin
                            d = (op == PUSH) ? din : (op == DUP) ? q[0] : q[1];
                            if (q.size() == 4) begin
                                void'(q.pop_back());
                                f = 1'b1;
                            end
                            q.push_front(d);
                        end
                    end
                    POP: if (q.size() == 0) f = 1'b1; else void'(q.pop_front());
                    SWAP: begin
                        if (q.size() < 2) f = 1'b1;
                        else begin a = q[0]; q[0] = q[1]; q[1] = a; end
                    end
                    ROT: begin
                        if (q.size() < 3) f = 1'b1;
                        else begin
                            a = q[0]; b = q[1]; c = q[2];
                            q[0] = c; q[1] = a; q[2] = b;
                        end
                    end
                    CLR: q.delete();
                    default: ;
                endcase
            end
            merr = f ? 1'b1 : (err_clr ? 1'b0 : merr);
        end
        if (mvalid) begin
            #1;
            chk("m_top", top, (q.size() > 0) ? q[0] : 8'h00);
            chk("m_second", second, (q.size() > 1) ? q[1] : 8'h00);
            chk("m_depth", depth, q.size());
            chk("m_empty", empty, q.size() == 0);
            chk("m_full", full, q.size() == 4);
            chk("m_err", err, merr);
        end
    end

    task automatic step(input bit v, input logic [2:0] o, input logic [7:0] d,
                        input bit c = 1'b0, input bit r = 1'b0);
        op_valid = v;
        op       = o;
        din      = d;
        err_clr  = c;
        rst      = r;
        @(negedge clk);
    endtask

    task automatic lit(input string name, input int exp_top, input int exp_second,
                       input int exp_depth, input int exp_err);
        chk({name, "_top"}, top, exp_top);
        chk({name, "_second"}, second, exp_second);
        chk({name, "_depth"}, depth, exp_depth);
        chk({name, "_err"}, err, exp_err);
    endtask

    initial begin
        step(1'b0, NOP, 8'h00, 1'b0, 1'b1);
        step(1'b0, NOP, 8'h00, 1'b0, 1'b1);
        lit("reset", 8'h00, 8'h00, 0, 0);
        chk("reset_empty", empty, 1);
        chk("reset_full", full, 0);

        step(1, PUSH, 8'h11); step(1, PUSH, 8'h22); step(1, PUSH, 8'h33);
        lit("push3", 8'h33, 8'h22, 3, 0);
        chk("push3_empty", empty, 0);
        chk("push3_full", full, 0);

        step(1, SWAP, 8'h00);
        lit("swap", 8'h22, 8'h33, 3, 0);
        step(1, ROT, 8'h00);
        lit("rot", 8'h11, 8'h22, 3, 0);
        step(1, POP, 8'h00); step(1, POP, 8'h00);
        lit("rot_third", 8'h33, 8'h00, 1, 0);

        step(1, CLR, 8'h00);
        for (int i = 1; i <= 4; i++) step(1, PUSH, 8'(i));
        lit("fill", 8'h04, 8'h03, 4, 0);
        chk("fill_full", full, 1);
        step(1, PUSH, 8'h55);
        lit("ovf", 8'h55, 8'h04, 4, 1);
        chk("ovf_full", full, 1);
        chk("pop0_top", top, 8'h55); step(1, POP, 8'h00);
        chk("pop1_top", top, 8'h04); step(1, POP, 8'h00);
        chk("pop2_top", top, 8'h03); step(1, POP, 8'h00);
        chk("pop3_top", top, 8'h02); step(1, POP, 8'h00);
        lit("drained", 8'h00, 8'h00, 0, 1);
        chk("drained_empty", empty, 1);

        step(0, NOP, 8'h00, 1'b1);
        chk("clr0_err", err, 0);
        step(1, POP, 8'h00);  lit("uf_pop", 8'h00, 8'h00, 0, 1);
        step(0, NOP, 8'h00, 1'b1);
        step(1, SWAP, 8'h00); lit("uf_swap", 8'h00, 8'h00, 0, 1);
        step(0, NOP, 8'h00, 1'b1);
        step(1, DUP, 8'h00);  lit("uf_dup", 8'h00, 8'h00, 0, 1);
        step(0, NOP, 8'h00, 1'b1);
        step(1, ROT, 8'h00);  lit("uf_rot", 8'h00, 8'h00, 0, 1);
        step(1, NOP, 8'h00, 1'b1);
        chk("errclr_err", err, 0);
        step(1, POP, 8'h00, 1'b1);
        chk("setwins_err", err, 1);

        step(1, PUSH, 8'h7A); step(1, DUP, 8'h00); step(1, OVER, 8'h00);
        lit("dupover", 8'h7A, 8'h7A, 3, 1);
        step(0, POP, 8'h00);
        lit("novalid", 8'h7A, 8'h7A, 3, 1);
        step(1, CLR, 8'h00);
        lit("clear", 8'h00, 8'h00, 0, 1);

        step(1, PUSH, 8'hA1); step(1, PUSH, 8'hB2); step(1, OVER, 8'h00);
        lit("over", 8'hA1, 8'hB2, 3, 1);
        step(1, PUSH, 8'hC3); step(1, OVER, 8'h00);
        lit("over_ovf", 8'hA1, 8'hC3, 4, 1);
        step(1, ROT, 8'h00);
        lit("rot_full", 8'hA1, 8'hA1, 4, 1);
        step(1, SWAP, 8'h00, 1'b1);
        chk("swap_clr_err", err, 0);

        step(1, CLR, 8'h00); step(1, POP, 8'h00);
        step(1, PUSH, 8'h0F); step(1, PUSH, 8'hF0);
        lit("pre_rst", 8'hF0, 8'h0F, 2, 1);
        step(1, PUSH, 8'hEE, 1'b1, 1'b1);
        lit("rst_mid", 8'h00, 8'h00, 0, 0);
        chk("rst_mid_empty", empty, 1);
        chk("rst_mid_full", full, 0);
        step(0, NOP, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
